mem_wb_lanes: RTL
=================

MEM_WB_LANES -- requirements
Module: mem_wb_lanes

Interface
REQ-001 The block SHALL expose parameter LANES, default 2, meaning the number of parallel write-back lanes (1..4).
REQ-002 The block SHALL expose parameter DATA_W, default 32, meaning the register write data width.
REQ-003 The block SHALL expose parameter ADDR_W, default 5, meaning the register address width.
REQ-004 The block SHALL expose parameter PAUSE_W, default 6, meaning the pipeline pause vector width.
REQ-005 The block SHALL expose parameter STAGE, default 4, meaning the pause bit index owned by this stage; legal range is 0..PAUSE_W-2, and any other value is an elaboration error.
REQ-006 The block SHALL expose parameter CNT_W, default 32, meaning the retire counter width.
REQ-007 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 Port pause, input, PAUSE_W bits: per-stage stall vector.
REQ-010 Port flush, input, 1 bit: discard the current stage contents.
REQ-011 Port mem_valid, input, LANES bits: lane i carries a real instruction.
REQ-012 Port mem_reg_write_data, input, LANES*DATA_W bits: lane i data at [i*DATA_W +: DATA_W].
REQ-013 Port mem_reg_write_addr, input, LANES*ADDR_W bits: lane i address at [i*ADDR_W +: ADDR_W].
REQ-014 Port mem_reg_write_en, input, LANES bits: lane i requests a register write.
REQ-015 Port wb_valid, output, LANES bits: registered copy of mem_valid.
REQ-016 Port wb_reg_write_data, output, LANES*DATA_W bits: registered write data.
REQ-017 Port wb_reg_write_addr, output, LANES*ADDR_W bits: registered write address.
REQ-018 Port wb_reg_write_en, output, LANES bits: qualified write enables.
REQ-019 Port retire_cnt, output, CNT_W bits: count of instructions retired through this stage.

Function
REQ-020 The block SHALL select its update per cycle by strict priority: rst, then flush, then bubble (pause[STAGE]=1 and pause[STAGE+1]=0), then advance (pause[STAGE]=0), then hold.
REQ-021 On flush or bubble the block SHALL clear every wb_* output to 0 on the next edge and leave retire_cnt unchanged.
REQ-022 On advance the block SHALL capture data, address and valid from all lanes, with a latency of exactly 1 cycle.
REQ-023 On advance the block SHALL set wb_reg_write_en[i] = mem_reg_write_en[i] & mem_valid[i] & (lane i addr != 0); writes to register 0 are never enabled.
REQ-024 On advance, for lanes i<j both qualified per REQ-023 with equal addresses, the block SHALL clear wb_reg_write_en[i] so that the youngest lane wins; data and address of lane i are still captured.
REQ-025 On advance the block SHALL add popcount(mem_valid) to retire_cnt, wrapping modulo 2^CNT_W with no saturation or flag.
REQ-026 On hold (pause[STAGE]=1 and pause[STAGE+1]=1) the block SHALL keep every output and retire_cnt unchanged.
REQ-027 When flush coincides with any pause pattern, the block SHALL apply flush and SHALL NOT count retirements.
REQ-028 Lanes SHALL be independent except for the collapse rule in REQ-024; an invalid lane never counts and never writes.

Reset
REQ-029 When rst=1 at a rising edge, the block SHALL clear all wb_* outputs and retire_cnt to 0, regardless of pause and flush.
REQ-030 Reset asserted while the stage is holding SHALL discard the held contents; the first edge after rst deasserts SHALL follow REQ-020 normally.

Verification
REQ-031 Advance test: LANES=2, pause=0, valid=11, en=11, addr0=3, addr1=7, data0=0xA, data1=0xB -> next cycle wb_en=11, wb_addr=7/3, wb_data=0xB/0xA, retire_cnt +2.
REQ-032 Collapse and x0 test: both lanes addr=5 and enabled -> wb_en=10; then lane0 addr=0, en=1 -> wb_en[0]=0.
REQ-033 Pause test: pause=010000 -> all wb_* = 0, count unchanged; pause=110000 -> outputs hold the prior values for 3 cycles.
REQ-034 Flush priority test: flush=1 with pause=110000 and valid=11 -> outputs 0 and retire_cnt unchanged.
REQ-035 Wrap test: CNT_W=4, preload to 15 via 15 single-lane advances, then advance with valid=11 -> retire_cnt=1.
REQ-036 Reset test: rst=1 during hold with retire_cnt=9 -> all outputs 0 next edge; after release, an advance with valid=01 -> retire_cnt=1.

Source files
------------

// File: rtl/mem_wb_lanes.sv
// -----------------------------------------------------------------------------
// mem_wb_lanes
//
// Purpose:
//   MEM -> WB pipeline register for a multi-lane (superscalar) core. Each
//   cycle the stage does one of the following, in strict priority order:
//     reset   - clear everything, including the retire counter
//     flush   - clear the write-back outputs, keep the retire counter
//     bubble  - this stage is paused but the next one is not, so a blank
//               slot is sent downstream
//     advance - capture every lane and count the valid instructions
//     hold    - this stage and the next are both paused, so keep everything
//
//   When a stage is captured, register write enables are qualified. A lane
//   writes only if it is valid, it requests a write, and its destination is
//   not register 0. If two qualified lanes target the same register, only
//   the youngest (highest-index) lane keeps its enable. The data and address
//   of the older lane are still captured.
//
// Ports:
//   clk                 in   single clock; all state updates on its rising edge
//   rst                 in   synchronous active-high reset
//   pause               in   per-stage stall vector; bit STAGE belongs to this
//                            stage and bit STAGE+1 to the stage after it
//   flush               in   discard the current stage contents
//   mem_valid           in   per-lane "real instruction" flag
//   mem_reg_write_data  in   lane i data at [i*DATA_W +: DATA_W]
//   mem_reg_write_addr  in   lane i address at [i*ADDR_W +: ADDR_W]
//   mem_reg_write_en    in   per-lane register write request
//   wb_valid            out  registered lane valid flags
//   wb_reg_write_data   out  registered write data
//   wb_reg_write_addr   out  registered write addresses
//   wb_reg_write_en     out  registered, qualified write enables
//   retire_cnt          out  running count of instructions retired here,
//                            wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module mem_wb_lanes #(
    parameter int LANES   = 2,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int PAUSE_W = 6,
    parameter int STAGE   = 4,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PAUSE_W-1:0]        pause,
    input  logic                      flush,
    input  logic [LANES-1:0]          mem_valid,
    input  logic [LANES*DATA_W-1:0]   mem_reg_write_data,
    input  logic [LANES*ADDR_W-1:0]   mem_reg_write_addr,
    input  logic [LANES-1:0]          mem_reg_write_en,
    output logic [LANES-1:0]          wb_valid,
    output logic [LANES*DATA_W-1:0]   wb_reg_write_data,
    output logic [LANES*ADDR_W-1:0]   wb_reg_write_addr,
    output logic [LANES-1:0]          wb_reg_write_en,
    output logic [CNT_W-1:0]          retire_cnt
);

    // Reject illegal configurations at elaboration. The stage needs a
    // downstream pause bit, so STAGE cannot be the top bit of the vector.
    if (STAGE < 0 || STAGE > PAUSE_W - 2) begin : g_bad_stage
        $error("mem_wb_lanes: STAGE must lie in 0..PAUSE_W-2");
    end
    if (LANES < 1 || LANES > 4) begin : g_bad_lanes
        $error("mem_wb_lanes: LANES must lie in 1..4");
    end

    // Pipeline register state
    logic [LANES-1:0]        valid_q, valid_d;
    logic [LANES*DATA_W-1:0] data_q,  data_d;
    logic [LANES*ADDR_W-1:0] addr_q,  addr_d;
    logic [LANES-1:0]        wen_q,   wen_d;
    logic [CNT_W-1:0]        cnt_q,   cnt_d;

    // Per-cycle decode of the stall vector
    logic do_bubble;
    logic do_advance;

    assign do_bubble  = pause[STAGE] & ~pause[STAGE+1];
    assign do_advance = ~pause[STAGE];

    // A lane is eligible to write only if it is valid, requests a write,
    // and does not target register 0.
    logic [LANES-1:0] qual;

    always_comb begin
        qual = '0;
        for (int i = 0; i < LANES; i++) begin
            qual[i] = mem_reg_write_en[i] & mem_valid[i]
                    & (mem_reg_write_addr[i*ADDR_W +: ADDR_W] != '0);
        end
    end

    // Same-register collapse: an eligible lane loses its enable when any
    // younger eligible lane writes the same register, so the youngest wins.
    logic [LANES-1:0] keep;

    always_comb begin
        keep = qual;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (qual[i] && qual[j] &&
                    (mem_reg_write_addr[i*ADDR_W +: ADDR_W] ==
                     mem_reg_write_addr[j*ADDR_W +: ADDR_W])) begin
                    keep[i] = 1'b0;
                end
            end
        end
    end

    // Number of valid lanes in the incoming group. Enables do not affect
    // this count, because a valid instruction retires even if it does not
    // write a register.
    logic [CNT_W-1:0] retire_inc;

    always_comb begin
        retire_inc = '0;
        for (int i = 0; i < LANES; i++) begin
            retire_inc = retire_inc + CNT_W'(mem_valid[i]);
        end
    end

    // Next-state selection. Flush overrides every pause pattern. Flush and
    // bubble both empty the slot but never count retirements.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        cnt_d   = cnt_q;
        if (flush || do_bubble) begin
            valid_d = '0;
            data_d  = '0;
            addr_d  = '0;
            wen_d   = '0;
        end else if (do_advance) begin
            valid_d = mem_valid;
            data_d  = mem_reg_write_data;
            addr_d  = mem_reg_write_addr;
            wen_d   = keep;
            cnt_d   = cnt_q + retire_inc;
        end
    end

    // State register. Reset wins over everything, including a hold, so any
    // held contents are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            wen_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_valid          = valid_q;
    assign wb_reg_write_data = data_q;
    assign wb_reg_write_addr = addr_q;
    assign wb_reg_write_en   = wen_q;
    assign retire_cnt        = cnt_q;

endmodule
